imem_debug_loader: RTL and testbench

IMEM_DEBUG_LOADER -- requirements
Module: imem_debug_loader

---
 rtl/imem_debug_loader.sv | 200 ++++++++++++++++++++
 tb/tb_imem_debug_loader.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_debug_loader.sv
// Byte-serial debug loader for the instruction RAM port B.
// The host sends a write command (op, addr x4, data x4) or a read command
// (op, addr x4); writes are acknowledged with one byte, reads return the
// addressed word MSB first, unknown opcodes get a single NAK byte.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for an opcode byte
// ADDR  | collecting the 4 address bytes, MSB first
// DATA  | collecting the 4 write-data bytes, MSB first
// WRITE | single-cycle RAM write pulse on port B
// ACK   | presenting ACK or NAK byte until the host takes it
// READ  | single-cycle RAM read, doutb captured at end of cycle
// RESP  | returning the captured word, 4 bytes MSB first
module imem_debug_loader #(
  parameter logic [7:0]  WR_OP    = 8'h57,
  parameter logic [7:0]  RD_OP    = 8'h52,
  parameter logic [7:0]  ACK_BYTE = 8'h4B,
  parameter logic [7:0]  NAK_BYTE = 8'h3F,
  parameter logic [31:0] TIMEOUT  = 32'd1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        web,
  output logic [29:0] addrb,
  output logic [31:0] dinb,
  input  logic [31:0] doutb,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    ACK   = 3'd4,
    READ  = 3'd5,
    RESP  = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic        is_wr_q, is_wr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] resp_q, resp_d;
  logic [7:0]  tx_q, tx_d;
  logic [31:0] idle_q, idle_d;
  logic [29:0] addr_hold_q, addr_hold_d;
  logic [31:0] din_hold_q, din_hold_d;

  logic rx_fire;
  logic tx_fire;
  logic in_rx_state;

  // Handshakes and outputs decoded from the registered state; web and
  // tx_valid therefore fall as soon as reset forces the state to IDLE.
  always_comb begin
    in_rx_state = (state_q == IDLE) || (state_q == ADDR) || (state_q == DATA);
    rx_ready    = rst_n & in_rx_state;
    tx_valid    = (state_q == ACK) || (state_q == RESP);
    web         = (state_q == WRITE);
    busy        = (state_q != IDLE);
    tx_data     = tx_q;
    rx_fire     = rx_ready & rx_valid;
    tx_fire     = tx_valid & tx_ready;
    // Port B sees the live address only while accessing; otherwise it
    // keeps the value from the last access.
    addrb       = ((state_q == WRITE) || (state_q == READ)) ? addr_q[31:2] : addr_hold_q;
    dinb        = (state_q == WRITE) ? data_q : din_hold_q;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    resp_d      = resp_q;
    tx_d        = tx_q;
    idle_d      = 32'd0;
    addr_hold_d = addr_hold_q;
    din_hold_d  = din_hold_q;

    case (state_q)
      IDLE: begin
        if (rx_fire) begin
          if ((rx_data == WR_OP) || (rx_data == RD_OP)) begin
            is_wr_d = (rx_data == WR_OP);
            cnt_d   = 2'd0;
            state_d = ADDR;
          end else begin
            tx_d    = NAK_BYTE;
            state_d = ACK;
          end
        end
      end

      ADDR: begin
        if (rx_fire) begin
          addr_d = {addr_q[23:0], rx_data};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = is_wr_q ? DATA : READ;
          end
        end else if (idle_q == TIMEOUT - 32'd1) begin
          // Host went quiet: drop the partial command silently.
          state_d = IDLE;
        end else begin
          idle_d = idle_q + 32'd1;
        end
      end

      DATA: begin
        if (rx_fire) begin
          data_d = {data_q[23:0], rx_data};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = WRITE;
          end
        end else if (idle_q == TIMEOUT - 32'd1) begin
          state_d = IDLE;
        end else begin
          idle_d = idle_q + 32'd1;
        end
      end

      WRITE: begin
        addr_hold_d = addr_q[31:2];
        din_hold_d  = data_q;
        tx_d        = ACK_BYTE;
        state_d     = ACK;
      end

      READ: begin
        addr_hold_d = addr_q[31:2];
        resp_d      = doutb;
        tx_d        = doutb[31:24];
        cnt_d       = 2'd0;
        state_d     = RESP;
      end

      ACK: begin
        if (tx_fire) begin
          state_d = IDLE;
        end
      end

      RESP: begin
        if (tx_fire) begin
          resp_d = {resp_q[23:0], 8'h00};
          tx_d   = resp_q[23:16];
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      is_wr_q     <= 1'b0;
      cnt_q       <= 2'd0;
      addr_q      <= 32'd0;
      data_q      <= 32'd0;
      resp_q      <= 32'd0;
      tx_q        <= 8'h00;
      idle_q      <= 32'd0;
      addr_hold_q <= 30'd0;
      din_hold_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      resp_q      <= resp_d;
      tx_q        <= tx_d;
      idle_q      <= idle_d;
      addr_hold_q <= addr_hold_d;
      din_hold_q  <= din_hold_d;
    end
  end

endmodule

// File: tb/tb_imem_debug_loader.sv
// Self-checking bench for imem_debug_loader: directed vector table,
// hand-written timeout / back-to-back / reset sequences, then random
// commands checked against a word-array model of the RAM contents.
module tb_imem_debug_loader;

  localparam logic [7:0] WR  = 8'h57;
  localparam logic [7:0] RD  = 8'h52;
  localparam logic [7:0] AK  = 8'h4B;
  localparam logic [7:0] NK  = 8'h3F;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        web;
  logic [29:0] addrb;
  logic [31:0] dinb;
  logic [31:0] doutb;
  logic        busy;

  imem_debug_loader #(.TIMEOUT(32'd16)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction RAM: combinational read, synchronous write.
  logic [31:0] ram [256];
  assign doutb = ram[addrb[7:0]];
  always @(posedge clk) if (web) ram[addrb[7:0]] <= dinb;

  // Write-pulse monitor.
  int          web_cnt = 0;
  logic [29:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;
  always @(negedge clk) begin
    if (web) begin
      web_cnt++;
      last_waddr = addrb;
      last_wdata = dinb;
    end
  end

  // Reference model state.
  logic [31:0] exp_mem [256];
  logic [29:0] exp_addrb;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      chk("rx_accept_wait", {31'd0, rx_ready}, 32'd1);
      rx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic recv_byte(input int stall, output logic [7:0] b);
    int n;
    bit stable;
    n = 0;
    stable = 1'b1;
    tx_ready = 1'b0;
    while (!tx_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!tx_valid) begin
      chk("tx_valid_wait", {31'd0, tx_valid}, 32'd1);
      b = 8'h00;
      return;
    end
    b = tx_data;
    repeat (stall) begin
      @(negedge clk);
      if (!tx_valid || tx_data !== b) stable = 1'b0;
    end
    if (stall > 0) chk("tx_hold_stable", {31'd0, stable}, 32'd1);
    tx_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  task automatic do_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input int stall, input int gapmax, output logic [31:0] resp);
    logic [7:0] b;
    int nb;
    resp = 32'd0;
    gap($urandom_range(0, gapmax));
    send_byte(op);
    if (op == WR || op == RD) begin
      for (int i = 3; i >= 0; i--) begin
        gap($urandom_range(0, gapmax));
        send_byte(addr[i*8 +: 8]);
      end
    end
    if (op == WR) begin
      for (int i = 3; i >= 0; i--) begin
        gap($urandom_range(0, gapmax));
        send_byte(data[i*8 +: 8]);
      end
    end
    nb = (op == RD) ? 4 : 1;
    for (int i = 0; i < nb; i++) begin
      recv_byte(stall, b);
      resp[31 - 8*i -: 8] = b;
    end
  endtask

  // Behavioural reference: what a command should do to memory and reply.
  task automatic model(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                       output int webs, output logic [31:0] resp);
    int idx;
    idx  = int'((addr / 4) % 256);
    webs = 0;
    if (op == WR) begin
      exp_mem[idx] = data;
      webs = 1;
      resp = {AK, 24'h0};
      exp_addrb = addr[31:2];
    end else if (op == RD) begin
      resp = exp_mem[idx];
      exp_addrb = addr[31:2];
    end else begin
      resp = {NK, 24'h0};
    end
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    int          stall;
    int          exp_webs;
    logic [29:0] exp_waddr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_resp;
    logic [29:0] exp_addrb;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [31:0] resp, mresp;
    int          w0, mwebs, nv;
    logic [7:0]  op;
    logic [31:0] addr, data;
    bit          quiet;
    logic [7:0]  got [4];

    vecs[0]  = '{8'h57, 32'h0000_0010, 32'hDEADBEEF, 0, 1, 30'h4,        32'hDEADBEEF, 32'h4B00_0000, 30'h4};
    vecs[1]  = '{8'h52, 32'h0000_0012, 32'h0,        0, 0, 30'h0,        32'h0,        32'hDEADBEEF,  30'h4};
    vecs[2]  = '{8'h41, 32'h0,         32'h0,        0, 0, 30'h0,        32'h0,        32'h3F00_0000, 30'h4};
    vecs[3]  = '{8'h57, 32'h0000_0013, 32'h12345678, 0, 1, 30'h4,        32'h12345678, 32'h4B00_0000, 30'h4};
    vecs[4]  = '{8'h52, 32'h0000_0010, 32'h0,        5, 0, 30'h0,        32'h0,        32'h12345678,  30'h4};
    vecs[5]  = '{8'h57, 32'h0000_00FC, 32'hCAFEF00D, 0, 1, 30'h3F,       32'hCAFEF00D, 32'h4B00_0000, 30'h3F};
    vecs[6]  = '{8'h52, 32'h0000_00FD, 32'h0,        2, 0, 30'h0,        32'h0,        32'hCAFEF00D,  30'h3F};
    vecs[7]  = '{8'hFF, 32'h0,         32'h0,        1, 0, 30'h0,        32'h0,        32'h3F00_0000, 30'h3F};
    vecs[8]  = '{8'h52, 32'h0000_0000, 32'h0,        0, 0, 30'h0,        32'h0,        32'hA5A5_0000, 30'h0};
    vecs[9]  = '{8'h57, 32'h8000_0104, 32'h0BADC0DE, 0, 1, 30'h2000_0041, 32'h0BADC0DE, 32'h4B00_0000, 30'h2000_0041};
    vecs[10] = '{8'h52, 32'h8000_0107, 32'h0,        3, 0, 30'h0,        32'h0,        32'h0BADC0DE,  30'h2000_0041};

    for (int i = 0; i < 256; i++) begin
      ram[i]     = 32'hA5A5_0000 | 32'(i);
      exp_mem[i] = 32'hA5A5_0000 | 32'(i);
    end
    exp_addrb = '0;

    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    #3;
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data",  {24'd0, tx_data},  32'd0);
    chk("rst_web",      {31'd0, web},      32'd0);
    chk("rst_addrb",    {2'd0, addrb},     32'd0);
    chk("rst_dinb",     dinb,              32'd0);
    chk("rst_busy",     {31'd0, busy},     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_rx_ready", {31'd0, rx_ready}, 32'd1);
    @(negedge clk);

    // Directed table.
    nv = 11;
    for (int i = 0; i < nv; i++) begin
      w0 = web_cnt;
      model(vecs[i].op, vecs[i].addr, vecs[i].data, mwebs, mresp);
      do_cmd(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].stall, 2, resp);
      chk($sformatf("vec%0d_resp", i), resp, vecs[i].exp_resp);
      chk($sformatf("vec%0d_webs", i), 32'(web_cnt - w0), 32'(vecs[i].exp_webs));
      if (vecs[i].exp_webs == 1) begin
        chk($sformatf("vec%0d_waddr", i), {2'd0, last_waddr}, {2'd0, vecs[i].exp_waddr});
        chk($sformatf("vec%0d_wdata", i), last_wdata, vecs[i].exp_wdata);
      end
      chk($sformatf("vec%0d_addrb", i), {2'd0, addrb}, {2'd0, vecs[i].exp_addrb});
      chk($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd0);
    end

    // Timeout in ADDR after two address bytes: silently back to IDLE.
    w0 = web_cnt;
    send_byte(WR);
    send_byte(8'h00);
    send_byte(8'h00);
    gap(15);
    chk("to_busy_before", {31'd0, busy}, 32'd1);
    gap(1);
    chk("to_busy_after", {31'd0, busy}, 32'd0);
    quiet = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (tx_valid) quiet = 1'b0;
    end
    chk("to_no_tx", {31'd0, quiet}, 32'd1);
    chk("to_no_web", 32'(web_cnt - w0), 32'd0);
    model(RD, 32'h0, 32'h0, mwebs, mresp);
    do_cmd(RD, 32'h0, 32'h0, 0, 0, resp);
    chk("to_next_read", resp, mresp);

    // Read with tx_ready held high: four bytes on four consecutive cycles.
    model(RD, 32'h0000_0010, 32'h0, mwebs, mresp);
    send_byte(RD);
    for (int i = 3; i >= 0; i--) send_byte(8'(32'h10 >> (8*i)));
    tx_ready = 1'b1;
    nv = 0;
    for (int c = 0; c < 12 && busy; c++) begin
      @(negedge clk);
      if (tx_valid) begin
        if (nv < 4) got[nv] = tx_data;
        nv++;
      end
    end
    tx_ready = 1'b0;
    chk("b2b_beats", 32'(nv), 32'd4);
    chk("b2b_word", {got[0], got[1], got[2], got[3]}, mresp);
    chk("b2b_busy", {31'd0, busy}, 32'd0);

    // Reset while the third data byte is on the link.
    w0 = web_cnt;
    send_byte(WR);
    for (int i = 3; i >= 0; i--) send_byte(8'(32'h20 >> (8*i)));
    send_byte(8'h11);
    send_byte(8'h22);
    rx_data  = 8'h33;
    rx_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rd_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("rd_busy",     {31'd0, busy},     32'd0);
    chk("rd_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rd_tx_data",  {24'd0, tx_data},  32'd0);
    chk("rd_addrb",    {2'd0, addrb},     32'd0);
    chk("rd_dinb",     dinb,              32'd0);
    rx_valid = 1'b0;
    exp_addrb = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rd_rel_ready", {31'd0, rx_ready}, 32'd1);
    quiet = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (tx_valid || busy) quiet = 1'b0;
    end
    chk("rd_quiet", {31'd0, quiet}, 32'd1);
    chk("rd_no_web", 32'(web_cnt - w0), 32'd0);

    // Reset during the write pulse itself: web must fall at once.
    send_byte(WR);
    for (int i = 3; i >= 0; i--) send_byte(8'(32'h24 >> (8*i)));
    for (int i = 3; i >= 0; i--) send_byte(8'(32'h55AA55AA >> (8*i)));
    chk("rw_web_high", {31'd0, web}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rw_web_low", {31'd0, web}, 32'd0);
    chk("rw_busy",    {31'd0, busy}, 32'd0);
    exp_addrb = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rw_no_ack", {31'd0, tx_valid}, 32'd0);
    model(RD, 32'h24, 32'h0, mwebs, mresp);
    do_cmd(RD, 32'h24, 32'h0, 0, 0, resp);
    chk("rw_mem_kept", resp, mresp);

    // Random commands against the model.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: op = WR;
        4, 5, 6, 7: op = RD;
        default: begin
          op = 8'($urandom);
          if (op == WR || op == RD) op = 8'h00;
        end
      endcase
      addr = $urandom;
      data = $urandom;
      w0 = web_cnt;
      model(op, addr, data, mwebs, mresp);
      do_cmd(op, addr, data, $urandom_range(0, 3), 3, resp);
      chk($sformatf("rnd%0d_resp", i), resp, mresp);
      chk($sformatf("rnd%0d_webs", i), 32'(web_cnt - w0), 32'(mwebs));
      if (mwebs == 1) begin
        chk($sformatf("rnd%0d_waddr", i), {2'd0, last_waddr}, {2'd0, addr[31:2]});
        chk($sformatf("rnd%0d_wdata", i), last_wdata, data);
      end
      chk($sformatf("rnd%0d_addrb", i), {2'd0, addrb}, {2'd0, exp_addrb});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
